// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, stage states, word widths and the
// settle-counter width helper used by alu_z_stage.
package alu_pkg;

  localparam int WORD_W  = 32;
  localparam int DWORD_W = 64;
  localparam int OP_W    = 4;

  localparam logic [OP_W-1:0] OP_AND  = 4'b0000;
  localparam logic [OP_W-1:0] OP_OR   = 4'b0001;
  localparam logic [OP_W-1:0] OP_XOR  = 4'b0010;
  localparam logic [OP_W-1:0] OP_ADD  = 4'b0011;
  localparam logic [OP_W-1:0] OP_SUB  = 4'b0100;
  localparam logic [OP_W-1:0] OP_MUL  = 4'b0101;
  localparam logic [OP_W-1:0] OP_DIV  = 4'b0110;
  localparam logic [OP_W-1:0] OP_NOT  = 4'b0111;
  localparam logic [OP_W-1:0] OP_NEG  = 4'b1000;
  localparam logic [OP_W-1:0] OP_SHL  = 4'b1001;
  localparam logic [OP_W-1:0] OP_SHR  = 4'b1010;
  localparam logic [OP_W-1:0] OP_ROL  = 4'b1011;
  localparam logic [OP_W-1:0] OP_SHRA = 4'b1100;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;

  // Counter must hold the largest wait; never narrower than one bit.
  function automatic int wait_cnt_w(int a, int b, int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/alu_z_stage_if.sv
// Request/result handshake bundle between the bus/control unit and alu_z_stage.
interface alu_z_stage_if;
  import alu_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] y_in;
  logic [WORD_W-1:0] b_in;
  logic [OP_W-1:0]   op_in;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] z_hi;
  logic [WORD_W-1:0] z_lo;
  logic              z_zero;
  logic [WORD_W-1:0] hi_out;
  logic [WORD_W-1:0] lo_out;

  modport master (
    output in_valid, y_in, b_in, op_in, out_ready,
    input  in_ready, out_valid, z_hi, z_lo, z_zero, hi_out, lo_out
  );

  modport slave (
    input  in_valid, y_in, b_in, op_in, out_ready,
    output in_ready, out_valid, z_hi, z_lo, z_zero, hi_out, lo_out
  );
endinterface

// File: rtl/alu_wait_counter.sv
// Settle-time down-counter: load on accept, decrement while executing.
module alu_wait_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         is_zero
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    cnt <= '0;
    else if (load)                 cnt <= load_val;
    else if (dec && cnt != '0)     cnt <= cnt - W'(1);
  end

  assign is_zero = (cnt == '0);
endmodule

// File: rtl/alu_z_stage.sv
// ALU sequencing / Z-capture stage. Optional divide-by-zero trap and sticky
// div0 flag are enabled by defining ALU_Z_STAGE_DIV0_TRAP_EN.
module alu_z_stage
  import alu_pkg::*;
#(
  parameter int MUL_WAIT  = 2,
  parameter int DIV_WAIT  = 4,
  parameter int BASE_WAIT = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_z_stage_if.slave       bus,
  output logic [WORD_W-1:0]  alu_a,
  output logic [WORD_W-1:0]  alu_b,
  output logic [OP_W-1:0]    alu_op,
  input  logic [DWORD_W-1:0] alu_result,
  input  logic               alu_zero
`ifdef ALU_Z_STAGE_DIV0_TRAP_EN
  ,
  output logic               div0
`endif
);
  localparam int CW = wait_cnt_w(MUL_WAIT, DIV_WAIT, BASE_WAIT);

  state_e             state;
  logic [DWORD_W-1:0] z_q;
  logic               z_zero_q;
  logic [WORD_W-1:0]  hi_q;
  logic [WORD_W-1:0]  lo_q;
  logic               out_valid_q;
  logic               in_ready;
  logic               accept;
  logic               div0_req;
  logic               trap_q;
  logic               cnt_zero;
  logic               cnt_dec;
  logic [CW-1:0]      load_val;

  assign in_ready = (state == IDLE) || (state == DONE && bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign cnt_dec  = (state == EXEC) && !cnt_zero;

`ifdef ALU_Z_STAGE_DIV0_TRAP_EN
  assign div0_req = (bus.op_in == OP_DIV) && (bus.b_in == '0);
`else
  assign div0_req = 1'b0;
`endif

  // A trapped divide skips the settle wait entirely.
  always_comb begin
    load_val = CW'(BASE_WAIT);
    if (bus.op_in == OP_MUL)      load_val = CW'(MUL_WAIT);
    else if (bus.op_in == OP_DIV) load_val = CW'(DIV_WAIT);
    if (div0_req)                 load_val = '0;
  end

  alu_wait_counter #(.W(CW)) u_wait (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .load_val (load_val),
    .dec      (cnt_dec),
    .is_zero  (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= '0;
      trap_q      <= 1'b0;
      z_q         <= '0;
      z_zero_q    <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      out_valid_q <= 1'b0;
`ifdef ALU_Z_STAGE_DIV0_TRAP_EN
      div0        <= 1'b0;
`endif
    end else begin
      if (accept) begin
        alu_a  <= bus.y_in;
        alu_b  <= bus.b_in;
        alu_op <= bus.op_in;
        trap_q <= div0_req;
      end
      case (state)
        IDLE: if (accept) state <= EXEC;
        EXEC: begin
          if (cnt_zero) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
            if (trap_q) begin
              z_q      <= '0;
              z_zero_q <= 1'b1;
`ifdef ALU_Z_STAGE_DIV0_TRAP_EN
              div0     <= 1'b1;
`endif
            end else begin
              z_q      <= alu_result;
              z_zero_q <= alu_zero;
              // HI = upper half (MUL high word / DIV remainder), LO = lower half.
              if (alu_op == OP_MUL || alu_op == OP_DIV) begin
                hi_q <= alu_result[DWORD_W-1:WORD_W];
                lo_q <= alu_result[WORD_W-1:0];
              end
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= accept ? EXEC : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.z_hi      = z_q[DWORD_W-1:WORD_W];
  assign bus.z_lo      = z_q[WORD_W-1:0];
  assign bus.z_zero    = z_zero_q;
  assign bus.hi_out    = hi_q;
  assign bus.lo_out    = lo_q;
endmodule
